// File: rtl/intr_entry_pkg.sv
// Shared types and constants for the interrupt/trap entry block.
package intr_entry_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    ENTER   = 2'd1,
    RETURN  = 2'd2,
    HANDLER = 2'd3
  } state_t;

  localparam logic [1:0] CSR_STATUS = 2'd0;
  localparam logic [1:0] CSR_EPC    = 2'd1;
  localparam logic [1:0] CSR_VEC    = 2'd2;
  localparam logic [1:0] CSR_CAUSE  = 2'd3;

  localparam logic [2:0] CAUSE_IRQ = 3'd0;
  localparam int         VEC_SHIFT = 2;

endpackage

// File: rtl/intr_save_stack.sv
// Save record store {epc, pie, code}: one slot by default, two-deep stack
// with sticky overflow when INTR_NEST_EN is defined.
module intr_save_stack
  import intr_entry_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_epc,
  input  logic              push_pie,
  input  logic [2:0]        push_code,
  input  logic              wr_epc,
  input  logic [ADDR_W-1:0] wr_epc_data,
  input  logic              wr_pie,
  input  logic              wr_pie_data,
  input  logic              clr_ovf,
  output logic [ADDR_W-1:0] top_epc,
  output logic              top_pie,
  output logic [2:0]        top_code,
  output logic [1:0]        depth,
  output logic              ovf
);

`ifdef INTR_NEST_EN
  logic [ADDR_W-1:0] epc_q [2];
  logic [2:0]        code_q [2];
  logic [1:0]        pie_q;
  logic [1:0]        depth_q;
  logic              ovf_q;
  logic              top_idx;
  logic              push_idx;

  // At depth 2 the top slot is reused, so push and top index coincide.
  assign top_idx  = (depth_q == 2'd2);
  assign push_idx = (depth_q != 2'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q[0]  <= '0;
      epc_q[1]  <= '0;
      code_q[0] <= '0;
      code_q[1] <= '0;
      pie_q     <= '0;
      depth_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (clr_ovf) ovf_q <= 1'b0;
      if (push) begin
        epc_q[push_idx]  <= push_epc;
        pie_q[push_idx]  <= push_pie;
        code_q[push_idx] <= push_code;
        if (depth_q == 2'd2) ovf_q <= 1'b1;
        else                 depth_q <= depth_q + 2'd1;
      end else if (pop) begin
        if (depth_q != 2'd0) depth_q <= depth_q - 2'd1;
      end else begin
        if (wr_epc) epc_q[top_idx] <= wr_epc_data;
        if (wr_pie) pie_q[top_idx] <= wr_pie_data;
      end
    end
  end

  assign top_epc  = epc_q[top_idx];
  assign top_pie  = pie_q[top_idx];
  assign top_code = code_q[top_idx];
  assign depth    = depth_q;
  assign ovf      = ovf_q;
`else
  logic [ADDR_W-1:0] epc_q;
  logic [2:0]        code_q;
  logic              pie_q;
  logic              unused_nest;

  always_ff @(posedge clk) begin
    if (reset) begin
      epc_q  <= '0;
      code_q <= '0;
      pie_q  <= 1'b0;
    end else if (push) begin
      epc_q  <= push_epc;
      pie_q  <= push_pie;
      code_q <= push_code;
    end else if (!pop) begin
      if (wr_epc) epc_q <= wr_epc_data;
      if (wr_pie) pie_q <= wr_pie_data;
    end
  end

  assign unused_nest = clr_ovf;
  assign top_epc  = epc_q;
  assign top_pie  = pie_q;
  assign top_code = code_q;
  assign depth    = 2'd0;
  assign ovf      = 1'b0;
`endif

endmodule

// File: rtl/intr_entry.sv
// Interrupt/trap entry and RTI sequencing with STATUS/EPC/VEC/CAUSE CSRs.
// Optional nesting stack enabled by defining INTR_NEST_EN.
module intr_entry
  import intr_entry_pkg::*;
#(
  parameter int               ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] VEC_RESET = 16'h0010
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              interrupt,
  input  logic              boundary,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              trap_req,
  input  logic [2:0]        trap_code,
  input  logic              rti,
  input  logic              csr_write,
  input  logic [1:0]        csr_addr,
  input  logic [15:0]       csr_wdata,
  output logic [15:0]       csr_rdata,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              in_handler,
  output logic              ie,
  output state_t            dbg_state
);

  // Handshake: redirect is a single-cycle pulse; redirect_pc is valid only
  // while redirect is high, and the core must flush and fetch from it.

  state_t            state;
  logic              ie_q;
  logic [ADDR_W-1:0] vec_q;
  logic              redirect_q;
  logic              take_rti, take_trap, take_irq, push, pop;
  logic [2:0]        entry_code;
  logic [ADDR_W-1:0] top_epc;
  logic              top_pie;
  logic [2:0]        top_code;
  logic [1:0]        depth;
  logic              ovf;
  logic              wr_status;

  always_comb begin
    take_rti  = 1'b0;
    take_trap = 1'b0;
    take_irq  = 1'b0;
    if (boundary && (state == RUN || state == HANDLER)) begin
      if (rti && state == HANDLER) take_rti  = 1'b1;
      else if (trap_req)           take_trap = 1'b1;
      else if (interrupt && ie_q)  take_irq  = 1'b1;
    end
  end

  assign push       = take_trap | take_irq;
  assign pop        = take_rti;
  assign entry_code = take_trap ? trap_code : CAUSE_IRQ;
  assign wr_status  = csr_write && (csr_addr == CSR_STATUS);

  intr_save_stack #(.ADDR_W(ADDR_W)) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .push_epc    (next_pc),
    .push_pie    (ie_q),
    .push_code   (entry_code),
    .wr_epc      (csr_write && (csr_addr == CSR_EPC)),
    .wr_epc_data (ADDR_W'(csr_wdata)),
    .wr_pie      (wr_status),
    .wr_pie_data (csr_wdata[1]),
    .clr_ovf     (wr_status && csr_wdata[2]),
    .top_epc     (top_epc),
    .top_pie     (top_pie),
    .top_code    (top_code),
    .depth       (depth),
    .ovf         (ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      ie_q        <= 1'b0;
      vec_q       <= VEC_RESET;
      redirect_q  <= 1'b0;
      redirect_pc <= '0;
      in_handler  <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      if (wr_status) ie_q <= csr_wdata[0];
      if (csr_write && csr_addr == CSR_VEC) vec_q <= ADDR_W'(csr_wdata) & ~ADDR_W'(3);
      case (state)
        RUN, HANDLER: begin
          if (push) begin
            ie_q        <= 1'b0;
            redirect_q  <= 1'b1;
            redirect_pc <= vec_q + (ADDR_W'(entry_code) << VEC_SHIFT);
            state       <= ENTER;
          end else if (pop) begin
            ie_q        <= top_pie;
            redirect_q  <= 1'b1;
            redirect_pc <= top_epc;
            state       <= RETURN;
          end
        end
        ENTER: begin
          state      <= HANDLER;
          in_handler <= 1'b1;
        end
        RETURN: begin
          state      <= (depth != 2'd0) ? HANDLER : RUN;
          in_handler <= (depth != 2'd0);
        end
        default: state <= RUN;
      endcase
    end
  end

  // Gated by reset so a reset landing on the flush cycle suppresses the pulse.
  assign redirect  = redirect_q & ~reset;
  assign ie        = ie_q;
  assign dbg_state = state;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      CSR_STATUS: csr_rdata = {13'h0, ovf, top_pie, ie_q};
      CSR_EPC:    csr_rdata = 16'(top_epc);
      CSR_VEC:    csr_rdata = 16'(vec_q);
      CSR_CAUSE:  csr_rdata = {10'h0, depth, 1'b0, top_code};
      default:    csr_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_intr_entry.sv
// Bench for intr_entry: directed scenarios plus random traffic against an
// architectural reference model of the single-slot (default) build.
module tb_intr_entry;
  import intr_entry_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        interrupt, boundary, trap_req, rti, csr_write;
  logic [15:0] next_pc, csr_wdata, csr_rdata, redirect_pc;
  logic [2:0]  trap_code;
  logic [1:0]  csr_addr;
  logic        redirect, in_handler, ie;
  state_t      dbg_state;

  intr_entry dut (
    .clk         (clk),
    .reset       (reset),
    .interrupt   (interrupt),
    .boundary    (boundary),
    .next_pc     (next_pc),
    .trap_req    (trap_req),
    .trap_code   (trap_code),
    .rti         (rti),
    .csr_write   (csr_write),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .in_handler  (in_handler),
    .ie          (ie),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  // reference model: architectural state plus a flush countdown
  logic        m_ie, m_pie, m_hand, m_redir;
  logic [15:0] m_epc, m_vec;
  logic [2:0]  m_cause;
  int          m_flush;  // 0 none, 1 entering, 2 returning

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {14'h0, m_pie, m_ie};
      2'd1:    return m_epc;
      2'd2:    return m_vec;
      default: return {13'h0, m_cause};
    endcase
  endfunction

  task automatic model_edge();
    logic       old_ie, old_pie;
    logic [15:0] old_epc, old_vec;
    int         acc;
    logic [2:0] code;
    m_redir = 1'b0;
    if (reset) begin
      m_ie = 0; m_pie = 0; m_epc = 0; m_vec = 16'h0010; m_cause = 0;
      m_hand = 0; m_flush = 0;
      return;
    end
    old_ie = m_ie; old_pie = m_pie; old_epc = m_epc; old_vec = m_vec;
    acc = 0; code = 3'd0;
    if (m_flush == 0 && boundary) begin
      if (rti && m_hand)           acc = 2;
      else if (trap_req)           begin acc = 1; code = trap_code; end
      else if (interrupt && old_ie) begin acc = 1; code = 3'd0; end
    end
    if (m_flush == 1) m_hand = 1'b1;
    if (m_flush == 2) m_hand = 1'b0;
    m_flush = 0;
    if (csr_write) begin
      case (csr_addr)
        2'd0: begin m_ie = csr_wdata[0]; m_pie = csr_wdata[1]; end
        2'd1: m_epc = csr_wdata;
        2'd2: m_vec = csr_wdata & 16'hFFFC;
        default: ;
      endcase
    end
    if (acc == 1) begin
      m_epc = next_pc; m_pie = old_ie; m_ie = 0; m_cause = code;
      m_flush = 1; m_redir = 1'b1;
      exp_q.push_back(16'(old_vec + 16'(code) * 16'd4));
    end else if (acc == 2) begin
      m_ie = old_pie; m_flush = 2; m_redir = 1'b1;
      exp_q.push_back(old_epc);
    end
  endtask

  task automatic check_outputs();
    check("redirect", redirect, m_redir);
    if (m_redir) check("redirect_pc", redirect_pc, exp_q.pop_front());
    check("in_handler", in_handler, m_hand);
    check("ie", ie, m_ie);
    check("csr_rdata", csr_rdata, model_read(csr_addr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    reset = 0; boundary = 0; trap_req = 0; rti = 0; csr_write = 0; csr_wdata = '0;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [15:0] d);
    idle_inputs();
    csr_write = 1; csr_addr = a; csr_wdata = d;
    cycle();
    csr_write = 0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [15:0] exp);
    csr_addr = a;
    #1;
    check(tag, csr_rdata, exp);
  endtask

  task automatic take_trap(input logic [2:0] c, input logic [15:0] pc);
    idle_inputs();
    boundary = 1; trap_req = 1; trap_code = c; next_pc = pc;
    cycle();
    idle_inputs();
  endtask

  task automatic do_rti();
    idle_inputs();
    boundary = 1; rti = 1;
    cycle();
    idle_inputs();
    cycle();
    cycle();
  endtask

  initial begin
    idle_inputs();
    interrupt = 0; next_pc = '0; trap_code = 3'd1; csr_addr = 2'd0;
    reset = 1;
    cycle();
    cycle();
    check("rst_redirect", redirect, 1'b0);
    check("rst_in_handler", in_handler, 1'b0);
    check("rst_state", dbg_state, RUN);
    read_check("rst_vec", 2'd2, 16'h0010);

    // interrupt entry with ie=1
    csr_wr(2'd0, 16'h0001);
    idle_inputs();
    interrupt = 1; boundary = 1; next_pc = 16'h0120;
    cycle();
    check("irq_redirect", redirect, 1'b1);
    check("irq_rpc", redirect_pc, 16'h0010);
    idle_inputs();
    cycle();
    check("irq_in_handler", in_handler, 1'b1);
    read_check("irq_epc", 2'd1, 16'h0120);
    read_check("irq_status", 2'd0, 16'h0002);

    // rti with interrupt still high re-enters after the RETURN cycle
    idle_inputs();
    boundary = 1; rti = 1; next_pc = 16'h0130;
    cycle();
    check("rti_rpc", redirect_pc, 16'h0120);
    check("rti_ie", ie, 1'b1);
    idle_inputs();
    boundary = 1;
    cycle();
    check("rti_no_same_cycle", redirect, 1'b0);
    boundary = 1; next_pc = 16'h0140;
    cycle();
    check("reenter_redirect", redirect, 1'b1);
    check("reenter_rpc", redirect_pc, 16'h0010);
    idle_inputs();
    cycle();
    read_check("reenter_cause", 2'd3, 16'h0000);
    interrupt = 0;
    do_rti();

    // trap code 5 with ie=0, VEC=0x0100
    csr_wr(2'd2, 16'h0100);
    csr_wr(2'd0, 16'h0000);
    take_trap(3'd5, 16'h0200);
    check("trap5_rpc", redirect_pc, 16'h0114);
    cycle();
    read_check("trap5_cause", 2'd3, 16'h0005);
    read_check("trap5_epc", 2'd1, 16'h0200);
    do_rti();

    // trap beats interrupt; concurrent STATUS write loses to the entry
    csr_wr(2'd0, 16'h0001);
    idle_inputs();
    interrupt = 1; boundary = 1; trap_req = 1; trap_code = 3'd3; next_pc = 16'h0300;
    csr_write = 1; csr_addr = 2'd0; csr_wdata = 16'h0000;
    cycle();
    check("prio_rpc", redirect_pc, 16'h010C);
    idle_inputs();
    cycle();
    check("prio_single_pulse1", redirect, 1'b0);
    cycle();
    check("prio_single_pulse2", redirect, 1'b0);
    read_check("prio_cause", 2'd3, 16'h0003);
    read_check("prio_status", 2'd0, 16'h0002);
    interrupt = 0;
    do_rti();

    // wrap-around of vector arithmetic
    csr_wr(2'd0, 16'h0000);
    csr_wr(2'd2, 16'hFFF0);
    take_trap(3'd7, 16'h0400);
    check("wrap_rpc", redirect_pc, 16'h000C);
    cycle();
    do_rti();

    // reset landing on the ENTER cycle
    take_trap(3'd2, 16'h0500);
    reset = 1;
    #1;
    check("rst_enter_redirect", redirect, 1'b0);
    cycle();
    check("rst_enter_in_handler", in_handler, 1'b0);
    check("rst_enter_state", dbg_state, RUN);
    read_check("rst_enter_status", 2'd0, 16'h0000);
    idle_inputs();
    cycle();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      idle_inputs();
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) interrupt = ~interrupt;
      boundary = 1'($urandom_range(0, 1));
      next_pc  = 16'($urandom);
      csr_addr = 2'($urandom_range(0, 3));
      if (boundary) begin
        trap_req  = ($urandom_range(0, 5) == 0);
        trap_code = 3'($urandom_range(1, 7));
        rti       = ($urandom_range(0, 3) == 0);
      end else if ($urandom_range(0, 9) == 0) begin
        csr_write = 1;
        csr_wdata = 16'($urandom);
      end
      cycle();
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_entry.md
Name: intr_entry

Overview:
- CPU-side consumer of the interrupt controller's `interrupt` line. It decides when the core takes an interrupt or software trap.
- It saves the return PC and the enable state, redirects fetch to a vectored handler, and restores state on return-from-interrupt (RTI).
- Sits between the interrupt controller and the core's fetch/decode stage.
- Owns a small CSR file (STATUS, EPC, VEC, CAUSE) on a 2-bit CSR port.

Parameters:
- ADDR_W, 16: width of PC, EPC, VEC and redirect address.
- VEC_RESET, 16'h0010: reset value of the VEC base register.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- interrupt  in  1  level request from the interrupt controller (OR of pending)
- boundary  in  1  core is at an instruction boundary; next_pc is valid this cycle
- next_pc  in  ADDR_W  address of the next instruction to execute
- trap_req  in  1  trap instruction retiring this cycle (valid only with boundary)
- trap_code  in  3  trap number 1..7
- rti  in  1  RTI instruction retiring this cycle (valid only with boundary)
- csr_write  in  1  CSR write strobe
- csr_addr  in  2  0 STATUS, 1 EPC, 2 VEC, 3 CAUSE
- csr_wdata  in  16  CSR write data
- csr_rdata  out  16  combinational CSR read data
- redirect  out  1  one-cycle pulse: core flushes and fetches from redirect_pc
- redirect_pc  out  ADDR_W  target address, valid while redirect is high
- in_handler  out  1  high from entry until RTI completes
- ie  out  1  global interrupt enable (STATUS[0])

Behaviour:
- Reset values: ie=0, pie=0, EPC=0, VEC=VEC_RESET, CAUSE=0, redirect=0, redirect_pc=0, in_handler=0, state=RUN.
- States: RUN, ENTER, RETURN, HANDLER.
- Priority in RUN/HANDLER, evaluated only when boundary=1: rti > trap_req > (interrupt & ie).
  - rti when not in_handler is ignored and treated as a nop.
- Trap accepted in cycle N:
  - at clock edge N: EPC<=next_pc, pie<=ie, ie<=0, CAUSE<={1'b0,trap_code}, state<=ENTER.
  - cycle N+1: redirect=1, redirect_pc=VEC+(CAUSE<<2).
  - cycle N+2: state=HANDLER, in_handler=1.
- Interrupt accepted: identical to a trap, with CAUSE=0, so redirect_pc=VEC.
  - interrupt is level-sampled. If it drops before a boundary with ie=1, nothing is taken.
- While in ENTER or RETURN: boundary, trap_req and rti are ignored (the core is flushing).
- RTI accepted in cycle N:
  - at edge N: ie<=pie, state<=RETURN.
  - cycle N+1: redirect=1, redirect_pc=EPC, in_handler<=0.
  - cycle N+2: state=RUN.
- RTI restoring ie=1 while interrupt is still high: the interrupt is taken at the first boundary after RETURN. This is never in the same cycle.
- Trap inside a handler (nesting disabled): EPC and pie are overwritten, same as any entry. Documented software hazard.
- CSR map:
  - STATUS = {14'h0, pie, ie}
  - EPC = next_pc saved at entry; RW
  - VEC: bits[1:0] read 0
  - CAUSE = {12'h0, nest_depth[1:0], CAUSE[1:0]}? No: CAUSE = {13'h0, code[2:0]}; RO, writes ignored.
- CSR write in the same cycle as an entry/RTI update: the hardware update wins for ie/pie/EPC/CAUSE. A VEC write always lands.
- Arithmetic: redirect_pc = VEC + {code,2'b00}, modulo 2^ADDR_W (wraps).
- Reset mid-ENTER/RETURN: state returns to RUN, no redirect is issued, and all registers take their reset values.

Optional Feature:
- INTR_NEST_EN defined:
  - 2-entry hardware stack of {EPC, pie, CAUSE}. Each entry pushes; RTI pops.
  - in_handler stays high until the depth returns to 0.
  - CAUSE[5:4] reads the depth.
  - An entry at depth 2 overwrites the top entry and sets a sticky overflow bit, STATUS[2], which is write-1-to-clear.
- INTR_NEST_EN undefined: single save slot as described above. STATUS[2] and CAUSE[5:4] read 0.

Decomposition:
- Package intr_entry_pkg:
  - state enum {RUN, ENTER, RETURN, HANDLER}
  - CSR address constants CSR_STATUS, CSR_EPC, CSR_VEC, CSR_CAUSE
  - CAUSE_IRQ=0
  - VEC shift constant = 2
- Sub-module intr_save_stack: push/pop of the save record. It has depth 1 without INTR_NEST_EN and depth 2 with it.

Test Plan:
- Reset, write STATUS=1, hold interrupt=1, pulse boundary with next_pc=0x0120:
  - redirect one cycle later with redirect_pc=0x0010.
  - EPC=0x0120, STATUS=0x0002, in_handler=1.
- trap_req with trap_code=5, boundary, VEC=0x0100, ie=0 -> redirect_pc=0x0114, CAUSE=5, EPC=next_pc.
- Same cycle: boundary, interrupt, trap_req code 3, ie=1 -> trap wins, CAUSE=3, exactly one redirect pulse.
- In handler: rti with interrupt still high and pie=1:
  - redirect_pc=EPC, ie=1 after RTI.
  - next boundary (not the RETURN cycle) re-enters with CAUSE=0.
- Wrap-around: VEC=0xFFF0, trap code 7 -> redirect_pc=0x000C.
- Assert reset in the ENTER cycle -> no redirect pulse, STATUS=0, in_handler=0, state RUN.
